// File: rtl/rom_pkg.sv
// rom_pkg: shared ROM geometry and address type
package rom_pkg;
  localparam int ROM_ADDR_W = 5;
  localparam int ROM_DEPTH = 32;
  typedef logic [ROM_ADDR_W-1:0] rom_addr_t;
endpackage

// File: rtl/rom_mux32.sv
// rom_mux32: balanced 32:1 mux tree (data_i, sel_i -> y_o), unknown select bits merge equal inputs and give X otherwise
module rom_mux32
  import rom_pkg::*;
(
  input  logic [ROM_DEPTH-1:0] data_i,
  input  rom_addr_t            sel_i,
  output logic                 y_o
);
  logic [2*ROM_DEPTH-2:0] t;
  assign t[ROM_DEPTH-1:0] = data_i;
  for (genvar j = 0; j < ROM_ADDR_W; j++) begin : g_lvl
    localparam int LO = 2*ROM_DEPTH - ((2*ROM_DEPTH) >> j);
    localparam int NO = 2*ROM_DEPTH - (ROM_DEPTH >> j);
    for (genvar i = 0; i < (ROM_DEPTH >> (j+1)); i++) begin : g_node
      assign t[NO+i] = sel_i[j] ? t[LO+2*i+1] : t[LO+2*i];
    end
  end
  assign y_o = t[2*ROM_DEPTH-2];
endmodule

// File: rtl/rom32x1.sv
// rom32x1: 32x1 ROM cell (o, a0..a4, clk, rst, ce, o_r); o = INIT[{a4..a0}] combinationally, o_r = copy captured on clk when ce, cleared asynchronously by rst low
module rom32x1
  import rom_pkg::*;
#(
  parameter logic [ROM_DEPTH-1:0] INIT = 32'h0000_0000
) (
  output logic o,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic a4,
  input  logic clk,
  input  logic rst,
  input  logic ce,
  output logic o_r
);
  rom_addr_t addr;
  logic o_r_q, o_r_d;
  assign addr = {a4, a3, a2, a1, a0};
  rom_mux32 u_mux (.data_i(INIT), .sel_i(addr), .y_o(o));
  assign o_r_d = ce ? o : o_r_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) o_r_q <= 1'b0;
    else o_r_q <= o_r_d;
  assign o_r = o_r_q;
endmodule

// File: tb/tb_rom32x1.sv
// tb_rom32x1: table, directed and random checks of rom32x1 against a shift-based reference
module tb_rom32x1;
  localparam logic [31:0] INIT0 = 32'h004760C0;
  typedef struct { logic [4:0] a; logic exp; } vec_t;
  logic clk, rst, ce, a0, a1, a2, a3, a4;
  logic o0, or0, o1, or1, o2, or2;
  int n_chk, n_fail;
  vec_t tbl [32];
  logic exp_r;
  rom32x1 #(.INIT(INIT0)) d0 (.o(o0), .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .clk(clk), .rst(rst), .ce(ce), .o_r(or0));
  rom32x1 #(.INIT(32'hFFFFFFFF)) d1 (.o(o1), .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .clk(clk), .rst(rst), .ce(ce), .o_r(or1));
  rom32x1 #(.INIT(32'h00000000)) d2 (.o(o2), .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .clk(clk), .rst(rst), .ce(ce), .o_r(or2));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic ref_bit(input logic [31:0] init, input int a);
    return logic'((init >> a) & 32'd1);
  endfunction
  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask
  task automatic set_a(input logic [4:0] a);
    {a4, a3, a2, a1, a0} = a;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) begin
      tbl[i].a = 5'(i);
      tbl[i].exp = (i == 6 || i == 7 || i == 13 || i == 14 || i == 16 || i == 17 || i == 18 || i == 22);
    end
    rst = 1'b0;
    ce = 1'b1;
    set_a(5'd6);
    tick();
    chk("reset o_r", or0, 1'b0);
    chk("reset o not reset", o0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    ce = 1'b0;
    for (int i = 0; i < 32; i++) begin
      set_a(tbl[i].a);
      #1;
      chk($sformatf("sweep o A=%0d", i), o0, tbl[i].exp);
      chk($sformatf("ones o A=%0d", i), o1, 1'b1);
      chk($sformatf("zeros o A=%0d", i), o2, 1'b0);
      tick();
      chk($sformatf("sweep o_r ce=0 A=%0d", i), or0, 1'b0);
    end
    {a4, a3, a1, a0} = 4'b0101;
    a2 = 1'bx;
    #1;
    chk("ones o a2=X", o1, 1'b1);
    chk("zeros o a2=X", o2, 1'b0);
    ce = 1'b1;
    set_a(5'd6);
    #1;
    chk("pipe o A=6", o0, 1'b1);
    tick();
    chk("pipe o_r A=6", or0, 1'b1);
    set_a(5'd0);
    #1;
    chk("pipe o A=0", o0, 1'b0);
    chk("pipe o_r lags", or0, 1'b1);
    tick();
    chk("pipe o_r A=0", or0, 1'b0);
    set_a(5'd22);
    #1;
    chk("pipe o_r lags 2", or0, 1'b0);
    tick();
    chk("pipe o_r A=22", or0, 1'b1);
    set_a(5'd7);
    tick();
    chk("ce capture A=7", or0, 1'b1);
    ce = 1'b0;
    set_a(5'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ce hold %0d", i), or0, 1'b1);
    end
    ce = 1'b1;
    tick();
    chk("ce resume A=0", or0, 1'b0);
    set_a(5'd7);
    tick();
    chk("pre-reset o_r", or0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async reset o_r", or0, 1'b0);
    chk("async reset o", o0, 1'b1);
    set_a(5'd6);
    @(posedge clk);
    rst <= 1'b1;
    #1;
    chk("release edge o_r", or0, 1'b0);
    tick();
    chk("post-release o_r", or0, 1'b1);
    exp_r = 1'b1;
    for (int k = 0; k < 300; k++) begin
      int a;
      a = int'($urandom_range(0, 31));
      set_a(5'(a));
      ce = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("rand o A=%0d", a), o0, ref_bit(INIT0, a));
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b0;
        exp_r = 1'b0;
        #1;
        chk("rand async reset", or0, exp_r);
        rst = 1'b1;
      end
      tick();
      if (ce) exp_r = ref_bit(INIT0, a);
      chk($sformatf("rand o_r A=%0d ce=%0b", a, ce), or0, exp_r);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rom32x1.md
# rom32x1

Single-bit, 32-deep read-only lookup cell with a 32-bit initialisation constant. It provides one bit of an 8-bit ROM slice: eight instances, each with its own constant and sharing one 5-bit address, form a 32-byte ROM row bank behind the 8051 program-memory fetch path. It keeps the asynchronous read of the vendor ROM32X1 cell and adds an optional registered copy of the output for pipelined fetch.

## Interface
Parameters:
- INIT, 32'h0000_0000, contents; bit n of INIT is the data stored at address n.

Ports:
- clk, in, 1, sole clock; rising edge.
- rst, in, 1, asynchronous, active-low reset; affects only the registered output.
- a0, in, 1, address bit 0 (LSB).
- a1, in, 1, address bit 1.
- a2, in, 1, address bit 2.
- a3, in, 1, address bit 3.
- a4, in, 1, address bit 4 (MSB).
- ce, in, 1, clock enable for the registered output.
- o, out, 1, combinational read data.
- o_r, out, 1, registered read data.

The pin order for positional instantiation is o, a0, a1, a2, a3, a4, then clk, rst, ce. Existing positional instances with six pins stay valid, and unconnected clk, rst and ce leave o unaffected.

## Operation
- Address: A = {a4,a3,a2,a1,a0}, unsigned, range 0..31. There is no out-of-range case.
- Combinational read: o = INIT[A] at all times, independent of clk, rst and ce.
- Registered read: on each rising clk edge with ce=1 and rst=1, o_r takes the current value of o. With ce=0, o_r holds its value.
- Reset: while rst=0, o_r = 0 immediately, without waiting for a clock edge. Reset has no effect on o.
- Unknown address (X or Z on any address bit), simulation only:
  - o = INIT bit when every address that matches the known bits selects the same INIT value.
  - Otherwise o = X.
- INIT is fixed at elaboration. There is no write port.

## Timing
- o: zero-cycle latency; a purely combinational path from a0–a4 to o.
- o_r: one-cycle latency. An address applied before edge k appears on o_r after edge k, provided ce=1 at edge k.
- Reset release: the first capture happens on the first rising edge with rst=1 and ce=1. On an edge where rst rises at the same time, o_r stays 0.
- Reset asserted mid-stream: o_r is forced to 0 asynchronously. o keeps tracking the address.
- Reset value of every output:
  - o_r = 0.
  - o = INIT[A]; it is not reset.

## Structure
- Shared package rom_pkg:
  - ROM_ADDR_W = 5.
  - ROM_DEPTH = 32.
  - An address typedef rom_addr_t, 5 bits.
- One natural sub-module, rom_mux32: a 32:1 bit multiplexer built as a balanced 2:1 tree, five levels with a0 at the leaves. It carries the X-merge rule at each 2:1 stage: equal inputs pass through, otherwise X. The top level holds the address concatenation, the rom_mux32 instance and the o_r flop.

## Test plan
- INIT=32'h004760C0:
  - Sweep A = 0..31 with ce=0 and rst=1.
  - o=1 exactly at A = 6, 7, 13, 14, 16, 17, 18, 22; o=0 elsewhere, including at A=0 and A=31.
- INIT=32'hFFFFFFFF and INIT=32'h00000000: every A gives o=1 and o=0 respectively. Drive a2=X with the other bits known: o stays 1 and 0 respectively, not X.
- Registered path, INIT=32'h004760C0, rst=1, ce=1:
  - Apply A=6, then A=0, then A=22 on successive edges.
  - o_r reads 1, 0, 1, each one cycle behind o.
- Clock enable: capture A=7, so o_r=1. Set ce=0, change to A=0, clock three times: o_r stays 1. Set ce=1, clock once: o_r=0.
- Asynchronous reset: with o_r=1, drive rst=0 between clock edges. o_r drops to 0 before the next edge, and o still shows INIT[A].
- Reset release: rst rises on the same edge where ce=1 and A=6, so o_r stays 0. The following edge gives o_r=1.
